snake_dir_ctrl: RTL

Input-conditioning stage that sits directly upstream of the `snake` game-logic block. It synchronizes and debounces the four raw direction buttons and rejects illegal turns: no reversal, no repeat, no multi-button chords. It buffers up to two pending turns and releases one committed direction per game tick as a registered `move` code with a one-cycle `move_valid` strobe. It replaces the combinational, latching button decode at the top level and owns game pacing.

---
 rtl/snake_dir_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/snake_dir_ctrl.sv
// Direction-button conditioning for the snake game: synchronize, debounce,
// filter illegal turns, buffer up to two turns and release one per game tick.
module snake_dir_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TICK_CYCLES     = 6250000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up,
    input  logic       right,
    input  logic       down,
    input  logic       left,
    input  logic       run,
    output logic [2:0] move,
    output logic       move_valid,
    output logic [1:0] queue_count
);

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_e;

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    function automatic logic is_reverse(input dir_e a, input dir_e b);
        case (a)
            DIR_UP:    is_reverse = (b == DIR_DOWN);
            DIR_RIGHT: is_reverse = (b == DIR_LEFT);
            DIR_DOWN:  is_reverse = (b == DIR_UP);
            DIR_LEFT:  is_reverse = (b == DIR_RIGHT);
            default:   is_reverse = 1'b0;
        endcase
    endfunction

    // Button vector bit order matches direction code minus one.
    function automatic dir_e onehot_to_dir(input logic [3:0] v);
        case (v)
            4'b0001: onehot_to_dir = DIR_UP;
            4'b0010: onehot_to_dir = DIR_RIGHT;
            4'b0100: onehot_to_dir = DIR_DOWN;
            4'b1000: onehot_to_dir = DIR_LEFT;
            default: onehot_to_dir = DIR_NONE;
        endcase
    endfunction

    logic [3:0] raw;
    assign raw = {left, down, right, up};

    // Synchronizer and debounce state
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      deb_q, deb_d;
    logic [3:0]      deb_prev_q, deb_prev_d;
    logic [DB_W-1:0] db_cnt_q [4];
    logic [DB_W-1:0] db_cnt_d [4];

    // Press detection
    logic [3:0] rise;
    logic       press_valid;
    dir_e       press_dir;

    // Game pacing
    logic              run_q, run_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    // Turn queue and committed direction
    dir_e       queue_q [2];
    dir_e       queue_d [2];
    dir_e       post_queue [2];
    logic [1:0] count_q, count_d, post_count;
    dir_e       move_q, move_d;
    dir_e       ref_dir;
    logic       move_valid_q, move_valid_d;
    logic       push;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is a lone debounced rise with every other button released.
    always_comb begin
        rise        = deb_q & ~deb_prev_q;
        press_valid = $onehot(rise) && (deb_q == rise);
        press_dir   = onehot_to_dir(rise);
    end

    // run_q delays counting by one cycle so the first tick lands TICK_CYCLES
    // edges after run is first sampled high.
    always_comb begin
        run_d = run;
        tick  = run && (tick_cnt_q == TICK_LAST);
        if (!run || !run_q || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    always_comb begin
        move_d       = move_q;
        move_valid_d = tick;
        post_queue   = queue_q;
        post_count   = count_q;

        if (tick && (count_q != 2'd0)) begin
            move_d        = queue_q[0];
            post_queue[0] = queue_q[1];
            post_queue[1] = DIR_NONE;
            post_count    = count_q - 2'd1;
        end

        // A push is judged against the queue as it stands after any pop.
        case (post_count)
            2'd0:    ref_dir = move_d;
            2'd1:    ref_dir = post_queue[0];
            default: ref_dir = post_queue[1];
        endcase

        push = press_valid && (post_count != 2'd2) && (press_dir != ref_dir)
            && !is_reverse(press_dir, ref_dir);

        queue_d = post_queue;
        count_d = post_count;
        if (push) begin
            queue_d[post_count[0]] = press_dir;
            count_d                = post_count + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_prev_q   <= '0;
            run_q        <= 1'b0;
            tick_cnt_q   <= '0;
            count_q      <= '0;
            move_q       <= DIR_NONE;
            move_valid_q <= 1'b0;
            // NOTE: the queue slots are cleared too, because a reset must drop pending turns.
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                queue_q[i] <= DIR_NONE;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_prev_d;
            run_q        <= run_d;
            tick_cnt_q   <= tick_cnt_d;
            count_q      <= count_d;
            move_q       <= move_d;
            move_valid_q <= move_valid_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            for (int i = 0; i < 2; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

    assign move        = move_q;
    assign move_valid  = move_valid_q;
    assign queue_count = count_q;

endmodule
